int_controller: RTL

Memory-mapped interrupt controller directly downstream of the timer blocks: it captures `o_intTMR`-style single-cycle interrupt pulses from up to eight sources, including the PWM timer. It holds them as pending flags, masks them, and presents one prioritised request with a vector to the core. The core retires the request through an acknowledge/return handshake. Register access uses the same 2-bit-address memory-map slot as the other map blocks.

---
 rtl/int_controller.sv | 96 +++++++++
 1 files changed

// File: rtl/int_controller.sv
// int_controller: eight-source masked, prioritised interrupt controller with MASK/PEND/STAT/SOFT registers.
// Define INTCTRL_EDGE_DETECT_EN to capture sources on 0->1 edges instead of on every high cycle.
module int_controller (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [1:0]  i_memAddr,
    input  logic [15:0] i_memDataIn,
    input  logic        i_memWrEn,
    output logic [15:0] o_memDataOut,
    input  logic        i_smIsBooted,
    input  logic        i_smStartPause,
    input  logic [7:0]  i_intSrc,
    input  logic        i_intAck,
    input  logic        i_intRet,
    output logic        o_intReq,
    output logic [2:0]  o_intVec
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
    state_t     r_state;
    logic [7:0] r_mask, r_pend;
    logic       r_gie;
    logic [7:0] w_src_set, w_soft_set, w_w1c, w_ack_clr, w_elig;
    logic       w_pause, w_ack, w_withdraw, w_unused;
    logic [2:0] w_win;

`ifdef INTCTRL_EDGE_DETECT_EN
    logic [7:0] r_src_prev;
    always_ff @(posedge i_clk or negedge i_rstn)
        if (!i_rstn) r_src_prev <= '0;
        else r_src_prev <= i_intSrc;
    assign w_src_set = i_intSrc & ~r_src_prev;
`else
    assign w_src_set = i_intSrc;
`endif

    assign w_unused   = ^i_memDataIn[15:8];
    assign w_pause    = ~i_smIsBooted | i_smStartPause;
    assign w_elig     = r_pend & r_mask & {8{r_gie & ~w_pause}};
    assign w_ack      = (r_state == REQ) & i_intAck;
    assign w_withdraw = ~(r_pend[o_intVec] & r_mask[o_intVec]) | ~r_gie | w_pause;
    assign w_w1c      = (i_memWrEn && i_memAddr == 2'b01) ? i_memDataIn[7:0] : 8'h00;
    assign w_soft_set = (i_memWrEn && i_memAddr == 2'b11) ? i_memDataIn[7:0] : 8'h00;
    assign w_ack_clr  = w_ack ? (8'h01 << o_intVec) : 8'h00;

    // Descending scan so the lowest eligible index is the last one written.
    always_comb begin
        w_win = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (w_elig[i]) w_win = 3'(i);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_mask <= '0;
            r_pend <= '0;
            r_gie  <= 1'b0;
        end else begin
            if (i_memWrEn && i_memAddr == 2'b00) r_mask <= i_memDataIn[7:0];
            if (i_memWrEn && i_memAddr == 2'b10) r_gie <= i_memDataIn[0];
            r_pend <= (r_pend & ~w_w1c & ~w_ack_clr) | w_src_set | w_soft_set;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state  <= IDLE;
            o_intReq <= 1'b0;
            o_intVec <= 3'd0;
        end else begin
            case (r_state)
                IDLE: if (|w_elig) begin
                    r_state  <= REQ;
                    o_intReq <= 1'b1;
                    o_intVec <= w_win;
                end
                REQ: if (w_ack) begin
                    r_state  <= SERVICE;
                    o_intReq <= 1'b0;
                end else if (w_withdraw) begin
                    r_state  <= IDLE;
                    o_intReq <= 1'b0;
                end
                SERVICE: if (i_intRet) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb
        case (i_memAddr)
            2'b00:   o_memDataOut = {8'h00, r_mask};
            2'b01:   o_memDataOut = {8'h00, r_pend};
            2'b10:   o_memDataOut = {9'h000, o_intVec, 2'b00, r_state == SERVICE, r_gie};
            default: o_memDataOut = 16'h0000;
        endcase
endmodule
